// File: rtl/filtro_pkg.sv
// Shared fixed-point constants and FSM encoding for the Q(1,8,14) filter datapath.
package filtro_pkg;

  localparam int W = 23;
  localparam int S = 1;
  localparam int M = 8;
  localparam int F = 14;

  // Clamp values shared with the saturating multiplier
  localparam logic [W-1:0] SAT_POS = 23'h3FFFFF;
  localparam logic [W-1:0] SAT_NEG = 23'h400000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    OUT  = 2'd2
  } state_t;

endpackage

// File: rtl/sumador_sat.sv
// Combinational W-bit two's-complement adder that clamps to SAT_POS/SAT_NEG on overflow.
module sumador_sat
  import filtro_pkg::*;
(
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] sum,
  output logic         ovf
);

  logic [W:0] full;

  always_comb begin
    full = {a[W-1], a} + {b[W-1], b};
    // Bits W and W-1 disagree exactly when the true sum does not fit in W bits
    ovf  = full[W] ^ full[W-1];
    if (!ovf)         sum = full[W-1:0];
    else if (full[W]) sum = SAT_NEG;
    else              sum = SAT_POS;
  end

endmodule

// File: rtl/fir_mac_secuencial.sv
// Sequential N-tap FIR: one multiplier tap per cycle, saturating accumulate, one output per Start.
module fir_mac_secuencial
  import filtro_pkg::*;
#(
  parameter int N = 5
) (
  input  logic         Clk,
  input  logic         Reset_n,
  input  logic         Start,
  input  logic [W-1:0] Xin,
  input  logic         Coef_We,
  input  logic [3:0]   Coef_Addr,
  input  logic [W-1:0] Coef_Data,
  output logic [W-1:0] Mul_A,
  output logic [W-1:0] Mul_B,
  input  logic [W-1:0] Mul_P,
  output logic [W-1:0] Yout,
  output logic         Done,
  output logic         Busy,
  output logic         Sat
);

  state_t       state_q, state_d;
  logic [3:0]   tap_q, tap_d;
  logic [W-1:0] acc_q, acc_d;
  logic [W-1:0] yout_q, yout_d;
  logic         done_q, done_d;
  logic         sat_q, sat_d;
  logic [W-1:0] x_q [N];
  logic [W-1:0] x_d [N];
  logic [W-1:0] coef_q [N];
  logic [W-1:0] coef_d [N];
  logic [W-1:0] sum;
  logic         ovf;

  sumador_sat u_sumador (
    .a  (acc_q),
    .b  (Mul_P),
    .sum(sum),
    .ovf(ovf)
  );

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    state_d = state_q;
    tap_d   = tap_q;
    acc_d   = acc_q;
    yout_d  = yout_q;
    done_d  = 1'b0;
    sat_d   = sat_q;
    x_d     = x_q;
    coef_d  = coef_q;
    Mul_A   = '0;
    Mul_B   = '0;
    Busy    = 1'b0;

    case (state_q)
      IDLE: begin
        // Addresses N and above match no entry and are silently ignored
        for (int k = 0; k < N; k++) begin
          if (Coef_We && Coef_Addr == 4'(k)) coef_d[k] = Coef_Data;
        end
        if (Start) begin
          for (int k = 1; k < N; k++) x_d[k] = x_q[k-1];
          x_d[0]  = Xin;
          acc_d   = '0;
          tap_d   = '0;
          state_d = MAC;
        end
      end

      MAC: begin
        Busy = 1'b1;
        for (int k = 0; k < N; k++) begin
          if (tap_q == 4'(k)) begin
            Mul_A = coef_q[k];
            Mul_B = x_q[k];
          end
        end
        acc_d = sum;
        if (ovf) sat_d = 1'b1;
        if (tap_q == 4'(N - 1)) state_d = OUT;
        else                    tap_d   = tap_q + 4'd1;
      end

      OUT: begin
        yout_d  = acc_q;
        done_d  = 1'b1;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= IDLE;
      tap_q   <= '0;
      acc_q   <= '0;
      yout_q  <= '0;
      done_q  <= 1'b0;
      sat_q   <= 1'b0;
      // NOTE: delay line and coefficient bank are explicitly cleared; a reset filter must output zero.
      for (int k = 0; k < N; k++) begin
        x_q[k]    <= '0;
        coef_q[k] <= '0;
      end
    end else begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge values.
      state_q <= state_d;
      tap_q   <= tap_d;
      acc_q   <= acc_d;
      yout_q  <= yout_d;
      done_q  <= done_d;
      sat_q   <= sat_d;
      x_q     <= x_d;
      coef_q  <= coef_d;
    end
  end

  assign Yout = yout_q;
  assign Done = done_q;
  assign Sat  = sat_q;

endmodule

// File: tb/tb_fir_mac_secuencial.sv
// Self-checking bench: saturating Q(1,8,14) multiplier model on Mul_P, and a sum-of-products reference filter.
module tb_fir_mac_secuencial;
  import filtro_pkg::*;

  localparam int N   = 5;
  localparam int LAT = N + 2;
  localparam longint MAXV = 64'sd4194303;
  localparam longint MINV = -64'sd4194304;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] xin = '0;
  logic         coef_we = 1'b0;
  logic [3:0]   coef_addr = '0;
  logic [W-1:0] coef_data = '0;
  logic [W-1:0] mul_a, mul_b, mul_p, yout;
  logic         done, busy, sat;

  int errors = 0;
  int checks = 0;

  // Reference state: tap history, coefficient bank, sticky saturation
  logic [W-1:0] m_x [N];
  logic [W-1:0] m_c [N];
  bit           m_sat;

  typedef struct {
    logic [W-1:0] xin;
    logic [W-1:0] y;
  } vec_t;
  vec_t tbl [5];

  always #5 clk = ~clk;

  fir_mac_secuencial #(.N(N)) dut (
    .Clk      (clk),
    .Reset_n  (rst_n),
    .Start    (start),
    .Xin      (xin),
    .Coef_We  (coef_we),
    .Coef_Addr(coef_addr),
    .Coef_Data(coef_data),
    .Mul_A    (mul_a),
    .Mul_B    (mul_b),
    .Mul_P    (mul_p),
    .Yout     (yout),
    .Done     (done),
    .Busy     (busy),
    .Sat      (sat)
  );

  function automatic longint sx(input logic [W-1:0] v);
    return longint'($signed(v));
  endfunction

  function automatic logic [W-1:0] mul_q(input logic [W-1:0] a, input logic [W-1:0] b);
    longint p;
    p = (sx(a) * sx(b)) >>> F;
    if (p > MAXV) p = MAXV;
    if (p < MINV) p = MINV;
    return p[W-1:0];
  endfunction

  always_comb mul_p = mul_q(mul_a, mul_b);

  function automatic logic [W-1:0] rnd_val();
    logic [W-1:0] v;
    case ($urandom_range(0, 3))
      0:       v = W'($urandom);
      1:       v = W'($urandom_range(0, 32'h1FFFF)) - W'(32'h10000);
      2:       v = ($urandom_range(0, 1) != 0) ? W'(32'h4000) : W'(32'h7FC000);
      default: v = '0;
    endcase
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    for (int k = 0; k < N; k++) begin
      m_x[k] = '0;
      m_c[k] = '0;
    end
    m_sat = 1'b0;
  endtask

  // y = saturating running sum over taps of coef[k]*x[n-k]
  task automatic model_sample(input logic [W-1:0] x, output logic [W-1:0] y);
    longint acc;
    for (int k = N - 1; k > 0; k--) m_x[k] = m_x[k-1];
    m_x[0] = x;
    acc = 0;
    for (int k = 0; k < N; k++) begin
      acc += sx(mul_q(m_c[k], m_x[k]));
      if (acc > MAXV) begin acc = MAXV; m_sat = 1'b1; end
      if (acc < MINV) begin acc = MINV; m_sat = 1'b1; end
    end
    y = acc[W-1:0];
  endtask

  // Entered and left at a falling edge; release lands right before the next sample may start
  task automatic do_reset();
    rst_n = 1'b0;
    model_clear();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic write_coef(input logic [3:0] addr, input logic [W-1:0] data);
    coef_we   = 1'b1;
    coef_addr = addr;
    coef_data = data;
    @(negedge clk);
    coef_we = 1'b0;
    if (addr < N) m_c[addr] = data;
  endtask

  // Called at a falling edge in IDLE; returns at the falling edge of the Done cycle
  task automatic do_sample(input logic [W-1:0] x, output logic [W-1:0] y_act);
    logic [W-1:0] exp_y;
    int  cyc;
    bit  seen;
    model_sample(x, exp_y);
    start = 1'b1;
    xin   = x;
    @(negedge clk);
    start = 1'b0;
    check("busy_mac", busy, 1);
    check("mul_a_tap0", mul_a, m_c[0]);
    check("mul_b_tap0", mul_b, m_x[0]);
    cyc  = 1;
    seen = done;
    while (!seen && cyc < 4 * LAT) begin
      @(negedge clk);
      cyc++;
      seen = done;
    end
    check("done_latency", seen ? cyc : 0, LAT);
    check("yout", yout, exp_y);
    check("sat", sat, m_sat);
    check("busy_idle", busy, 0);
    check("mul_a_idle", mul_a, 0);
    y_act = yout;
  endtask

  initial begin
    logic [W-1:0] y;
    int dones, first;
    logic [W-1:0] y_first, exp_y;

    model_clear();
    #2 rst_n = 1'b0;
    #1;
    check("rst_yout", yout, 0);
    check("rst_done", done, 0);
    check("rst_busy", busy, 0);
    check("rst_sat", sat, 0);
    check("rst_mul_a", mul_a, 0);
    check("rst_mul_b", mul_b, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Impulse response: out-of-range addresses must not disturb the bank
    tbl[0] = '{23'h004000, 23'h004000};
    tbl[1] = '{23'h000000, 23'h002000};
    tbl[2] = '{23'h000000, 23'h001000};
    tbl[3] = '{23'h000000, 23'h000000};
    tbl[4] = '{23'h000000, 23'h000000};
    write_coef(4'd0, 23'h004000);
    write_coef(4'd1, 23'h002000);
    write_coef(4'd2, 23'h001000);
    write_coef(4'd3, 23'h000000);
    write_coef(4'd4, 23'h000000);
    write_coef(4'd5, 23'h123456);
    write_coef(4'd15, 23'h2ABCDE);
    for (int i = 0; i < 5; i++) begin
      do_sample(tbl[i].xin, y);
      check("impulse", y, tbl[i].y);
    end
    check("impulse_sat", sat, 0);

    // Positive saturation
    do_reset();
    for (int k = 0; k < N; k++) write_coef(4'(k), 23'h004000);
    do_sample(23'h3C0000, y);
    check("pos_first", y, 23'h3C0000);
    do_sample(23'h3C0000, y);
    check("pos_clamp", y, 23'h3FFFFF);
    check("pos_sat", sat, 1);

    // Negative saturation
    do_reset();
    for (int k = 0; k < N; k++) write_coef(4'(k), 23'h004000);
    do_sample(23'h440000, y);
    check("neg_first", y, 23'h440000);
    do_sample(23'h440000, y);
    check("neg_clamp", y, 23'h400000);
    check("neg_sat", sat, 1);

    // Reset in MAC cycle 3: everything clears at once, aborted sequence never completes
    start = 1'b1;
    xin   = 23'h004000;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mid_rst_yout", yout, 0);
    check("mid_rst_done", done, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_sat", sat, 0);
    check("mid_rst_mul_a", mul_a, 0);
    check("mid_rst_mul_b", mul_b, 0);
    model_clear();
    @(negedge clk);
    rst_n = 1'b1;
    dones = 0;
    for (int c = 0; c < LAT + 2; c++) begin
      @(negedge clk);
      if (done) dones++;
    end
    check("mid_rst_no_done", dones, 0);
    do_sample(23'h004000, y);
    check("mid_rst_coef_clear", y, 0);

    // Dropped Start (cycles 2, 4) and Coef_We (cycle 3) during MAC
    do_reset();
    for (int k = 0; k < N; k++) write_coef(4'(k), W'(32'h1000 * (k + 1)));
    do_sample(23'h00A000, y);
    do_sample(23'h7F6000, y);
    model_sample(23'h013000, exp_y);
    start = 1'b1;
    xin   = 23'h013000;
    dones = 0;
    first = 0;
    y_first = '0;
    for (int c = 1; c <= 2 * LAT; c++) begin
      @(negedge clk);
      start     = (c == 2 || c == 4);
      xin       = (c == 2 || c == 4) ? 23'h2A0000 : xin;
      coef_we   = (c == 3);
      coef_addr = 4'd0;
      coef_data = 23'h1FFFFF;
      if (done) begin
        dones++;
        if (first == 0) begin
          first   = c;
          y_first = yout;
        end
      end
    end
    start   = 1'b0;
    coef_we = 1'b0;
    check("drop_one_done", dones, 1);
    check("drop_done_cycle", first, LAT);
    check("drop_yout", y_first, exp_y);
    do_sample(23'h005000, y);

    // Back-to-back random samples: Start lands in each Done cycle
    for (int k = 0; k < N; k++) write_coef(4'(k), rnd_val());
    for (int i = 0; i < 10; i++) do_sample(rnd_val(), y);

    // Random coefficients and samples with idle gaps
    for (int r = 0; r < 4; r++) begin
      for (int k = 0; k < N; k++) write_coef(4'(k), rnd_val());
      for (int i = 0; i < 6; i++) begin
        do_sample(rnd_val(), y);
        repeat ($urandom_range(0, 3)) @(negedge clk);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
